// File: rtl/store_buffer_pkg.sv
// Shared sizing constants for the store buffer and its match logic.
package store_buffer_pkg;

  localparam int unsigned SB_DEPTH  = 4;
  localparam int unsigned SB_ADDR_W = 32;
  localparam int unsigned SB_DATA_W = 32;

  // Byte-offset bits below the word address; ignored for matching.
  localparam int unsigned WORD_OFF  = 2;

endpackage : store_buffer_pkg

// File: rtl/store_buffer_match.sv
// Youngest-hit search over the buffered store addresses for load forwarding.
module sb_match
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = SB_DEPTH,
  parameter int unsigned ADDR_W = SB_ADDR_W,
  parameter int unsigned PTR_W  = $clog2(SB_DEPTH)
) (
  input  logic [DEPTH-1:0]             valid,
  input  logic [DEPTH-1:0][ADDR_W-1:0] addrs,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [PTR_W-1:0]             tail,
  output logic                         hit,
  output logic [PTR_W-1:0]             idx
);

  logic [PTR_W-1:0] slot;
  logic             unused;

  // Byte-offset bits never take part in the compare.
  always_comb begin
    unused = ^addr[WORD_OFF-1:0];
    for (int unsigned k = 0; k < DEPTH; k++) begin
      unused = unused ^ (^addrs[k][WORD_OFF-1:0]);
    end
  end

  // Walk slots from tail (oldest side) toward tail-1 (youngest); last match wins.
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    slot = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      slot = tail + PTR_W'(k);
      if (valid[slot] &&
          (addrs[slot][ADDR_W-1:WORD_OFF] == addr[ADDR_W-1:WORD_OFF])) begin
        hit = 1'b1;
        idx = slot;
      end
    end
  end

endmodule : sb_match

// File: rtl/store_buffer.sv
// Store FIFO between the CPU MEM stage and a single-port data memory, with
// load priority on the port and youngest-entry store-to-load forwarding.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = SB_DEPTH,
  parameter int unsigned ADDR_W = SB_ADDR_W,
  parameter int unsigned DATA_W = SB_DATA_W
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  input  logic                    cpu_store,
  input  logic                    cpu_load,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    stall,
  input  logic                    flush,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic                    mem_store,
  input  logic [DATA_W-1:0]       mem_rdata,
  input  logic                    mem_ready
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [DEPTH-1:0]             valid_q;
  logic [PTR_W-1:0]             head_q;
  logic [PTR_W-1:0]             tail_q;
  logic [CNT_W-1:0]             count_q;
  logic [CNT_W-1:0]             count_d;
  logic                         empty_q;

  logic                         load_req;
  logic                         drain;
  logic                         push;
  logic                         hit;
  logic [PTR_W-1:0]             hit_idx;
  logic                         unused;

  // Flush is a software-visible handshake only; the CPU watches empty.
  assign unused = flush;

  // Forwarding search against every valid buffered store.
  sb_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .PTR_W  (PTR_W)
  ) u_match (
    .valid (valid_q),
    .addrs (addr_q),
    .addr  (cpu_addr),
    .tail  (tail_q),
    .hit   (hit),
    .idx   (hit_idx)
  );

  // Port arbitration, push/pop decisions and occupancy update.
  always_comb begin
    load_req = cpu_load & ~cpu_store;  // an illegal load+store is treated as the store
    drain    = (count_q != '0) && !load_req && mem_ready;
    push     = cpu_store && ((count_q < CNT_W'(DEPTH)) || drain);
    stall    = cpu_store && (count_q == CNT_W'(DEPTH)) && !drain;
    count_d  = count_q + CNT_W'(push) - CNT_W'(drain);
  end

  // Memory port mux and load return path.
  always_comb begin
    mem_addr  = load_req ? cpu_addr : addr_q[head_q];
    mem_wdata = data_q[head_q];
    mem_store = drain;
    cpu_rdata = hit ? data_q[hit_idx] : mem_rdata;
  end

  // Pointers, valid bits and occupancy; a same-edge push wins over a pop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
    end else begin
      if (drain) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PTR_W'(1);
      end
      count_q <= count_d;
      empty_q <= (count_d == '0);
    end
  end

  // Entry payload storage; contents are qualified by valid_q.
  always_ff @(posedge CLK) begin
    if (push) begin
      addr_q[tail_q] <= cpu_addr;
      data_q[tail_q] <= cpu_wdata;
    end
  end

  assign count = count_q;
  assign empty = empty_q;

endmodule : store_buffer

// File: tb/tb_store_buffer.sv
// Directed scoreboard bench for store_buffer: expected memory writes and load
// results are queued by the stimulus and checked by an independent monitor.
module tb_store_buffer;

  logic        CLK;
  logic        RST;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_store;
  logic        cpu_load;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        flush;
  logic        empty;
  logic [2:0]  count;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_store;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         wr_q[$];
  logic [31:0] ld_q[$];
  logic [31:0] mem_arr [0:63];

  int checks = 0;
  int errors = 0;

  store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_store (cpu_store),
    .cpu_load  (cpu_load),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .flush     (flush),
    .empty     (empty),
    .count     (count),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_store (mem_store),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Word-addressed data memory model, combinational read.
  assign mem_rdata = mem_arr[mem_addr[7:2]];
  always @(posedge CLK) if (mem_store) mem_arr[mem_addr[7:2]] <= mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  // One accepted store; exp selects whether it must later reach memory.
  task automatic st(input logic [31:0] a, input logic [31:0] d, input bit exp);
    wr_t w;
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_store = 1'b1;
    if (exp) begin
      w.a = a;
      w.d = d;
      wr_q.push_back(w);
    end
    sample();
    chk("store_no_stall", 32'(stall), 32'd0);
    tick();
    cpu_store = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    sample();
    while (!empty && n < 40) begin
      tick();
      sample();
      n++;
    end
    chk(name, 32'(empty), 32'd1);
    tick();
  endtask

  // Monitor: every memory write and every load result is matched to the queues.
  always @(negedge CLK) begin
    if (!RST) begin
      if (mem_store) begin
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=%h:%h required=none", mem_addr, mem_wdata);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          chk("write_addr", mem_addr, e.a);
          chk("write_data", mem_wdata, e.d);
        end
      end
      if (cpu_load) begin
        if (ld_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_load actual=%h required=none", cpu_rdata);
        end else begin
          logic [31:0] e;
          e = ld_q.pop_front();
          chk("load_data", cpu_rdata, e);
        end
      end
      if (cpu_load && cpu_store) begin
        errors++;
        $display("FAIL illegal_load_store actual=1 required=0");
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) mem_arr[i] = 32'h0;
    mem_arr[6'h14] = 32'h0000_1234;  // 0x50
    mem_arr[6'h1C] = 32'h0000_7777;  // 0x70
    mem_arr[6'h24] = 32'h0000_9999;  // 0x90
    RST = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_store = 1'b0;
    cpu_load = 1'b0; flush = 1'b0; mem_ready = 1'b1;
    tick(); tick();
    RST = 1'b0;
    sample();
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_mem_store", 32'(mem_store), 32'd0);
    tick();

    // 1: single store retires the following cycle.
    st(32'h10, 32'hAAAA_0001, 1'b1);
    sample();
    chk("t1_mem_store", 32'(mem_store), 32'd1);
    chk("t1_count", 32'(count), 32'd1);
    tick();
    sample();
    chk("t1_empty", 32'(empty), 32'd1);
    chk("t1_count0", 32'(count), 32'd0);
    tick();

    // 2: fill, stall, then simultaneous pop and push.
    mem_ready = 1'b0;
    st(32'h20, 32'hC0DE_0020, 1'b1);
    st(32'h24, 32'hC0DE_0024, 1'b1);
    st(32'h28, 32'hC0DE_0028, 1'b1);
    st(32'h2C, 32'hC0DE_002C, 1'b1);
    cpu_addr = 32'h30; cpu_wdata = 32'hC0DE_0030; cpu_store = 1'b1;
    wr_q.push_back('{a: 32'h30, d: 32'hC0DE_0030});
    sample();
    chk("t2_count_full", 32'(count), 32'd4);
    chk("t2_stall", 32'(stall), 32'd1);
    tick();
    mem_ready = 1'b1;
    sample();
    chk("t2_stall_drop", 32'(stall), 32'd0);
    chk("t2_drain", 32'(mem_store), 32'd1);
    tick();
    cpu_store = 1'b0;
    sample();
    chk("t2_count_held", 32'(count), 32'd4);
    tick();
    wait_empty("t2_empty");

    // 3: forwarding picks the youngest duplicate; byte bits ignored.
    mem_ready = 1'b0;
    st(32'h40, 32'h0000_0001, 1'b1);
    st(32'h40, 32'h0000_0002, 1'b1);
    mem_ready = 1'b1; cpu_load = 1'b1; cpu_addr = 32'h40;
    ld_q.push_back(32'h0000_0002);
    sample();
    chk("t3_no_drain", 32'(mem_store), 32'd0);
    tick();
    cpu_addr = 32'h42;
    ld_q.push_back(32'h0000_0002);
    sample();
    chk("t3_no_drain_b", 32'(mem_store), 32'd0);
    tick();
    cpu_load = 1'b0;
    wait_empty("t3_empty");
    chk("t3_mem_final", mem_arr[6'h10], 32'h0000_0002);

    // 4: load miss reads memory and blocks the drain for that cycle.
    mem_ready = 1'b0;
    st(32'h60, 32'h6060_6060, 1'b1);
    st(32'h64, 32'h6464_6464, 1'b1);
    st(32'h68, 32'h6868_6868, 1'b1);
    mem_ready = 1'b1; cpu_load = 1'b1; cpu_addr = 32'h50;
    ld_q.push_back(32'h0000_1234);
    sample();
    chk("t4_no_drain", 32'(mem_store), 32'd0);
    chk("t4_count", 32'(count), 32'd3);
    tick();
    cpu_load = 1'b0;
    sample();
    chk("t4_drain_resume", 32'(mem_store), 32'd1);
    tick();
    wait_empty("t4_empty");

    // 5: reset discards pending stores.
    mem_ready = 1'b0;
    st(32'h70, 32'hDEAD_0070, 1'b0);
    st(32'h74, 32'hDEAD_0074, 1'b0);
    st(32'h78, 32'hDEAD_0078, 1'b0);
    sample();
    chk("t5_count3", 32'(count), 32'd3);
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0; mem_ready = 1'b1; cpu_load = 1'b1; cpu_addr = 32'h70;
    ld_q.push_back(32'h0000_7777);
    sample();
    chk("t5_count0", 32'(count), 32'd0);
    chk("t5_empty", 32'(empty), 32'd1);
    chk("t5_mem_store", 32'(mem_store), 32'd0);
    tick();
    cpu_load = 1'b0;
    sample();
    chk("t5_no_write", 32'(mem_store), 32'd0);
    tick();
    tick();

    // 6: full buffer, alternating loads; writes only on idle cycles, in order.
    mem_ready = 1'b0;
    st(32'h80, 32'h8080_0000, 1'b1);
    st(32'h84, 32'h8484_0000, 1'b1);
    st(32'h88, 32'h8888_0000, 1'b1);
    st(32'h8C, 32'h8C8C_0000, 1'b1);
    sample();
    chk("t6_full", 32'(count), 32'd4);
    tick();
    mem_ready = 1'b1; cpu_addr = 32'h90;
    for (int i = 0; i < 8; i++) begin
      cpu_load = ((i % 2) == 0);
      if (cpu_load) ld_q.push_back(32'h0000_9999);
      sample();
      chk("t6_write_slot", 32'(mem_store), 32'(!cpu_load));
      tick();
    end
    cpu_load = 1'b0;
    wait_empty("t6_empty");

    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    chk("ld_q_drained", 32'(ld_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_store_buffer
